// File: rtl/lr_intctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lr_intctl_if
//  Description : CPU bus and core interrupt handshake bundle between the
//                lr35902 core (master) and the interrupt controller (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface lr_intctl_if;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic        load;
    logic        store;
    logic [7:0]  rdata;
    logic        rsel;
    logic        intreq;
    logic [15:0] intaddress;
    logic        intack;

    modport master (
        output address, wdata, load, store, intack,
        input  rdata, rsel, intreq, intaddress
    );

    modport slave (
        input  address, wdata, load, store, intack,
        output rdata, rsel, intreq, intaddress
    );
endinterface
`default_nettype wire

// File: rtl/lr_intctl.sv
`default_nettype none
// ============================================================================
//  Module      : lr_intctl
//  Description : Interrupt controller for the lr35902 core. Edge-detects the
//                peripheral lines into IF, masks with IE, drives the
//                highest-priority vector and serves CPU access to IF/IE.
//  Revision    : 1.0  initial release
// ============================================================================
module lr_intctl #(
    parameter int          NSRC       = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int          VEC_STRIDE = 8,
    parameter logic [15:0] IF_ADDR    = 16'hFF0F,
    parameter logic [15:0] IE_ADDR    = 16'hFFFF
) (
    input  wire logic            clock4,
    input  wire logic            resetn,
    input  wire logic [NSRC-1:0] irq_src,
    lr_intctl_if.slave           bus
);

    logic [NSRC-1:0] if_q, if_d;
    logic [7:0]      ie_q, ie_d;
    logic [NSRC-1:0] src_q;
    logic            ack_q;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] ack_mask;
    logic [15:0]     vec;
    logic            ack_edge;
    logic            if_hit;
    logic            ie_hit;
    logic [7:0]      if_rd;

    assign rise     = irq_src & ~src_q;
    assign pend     = if_q & ie_q[NSRC-1:0];
    assign ack_edge = bus.intack & ~ack_q;
    assign if_hit   = (bus.address == IF_ADDR);
    assign ie_hit   = (bus.address == IE_ADDR);

    // Lowest set pending bit wins: scan from the top so the last hit is the lowest index
    always_comb begin
        ack_mask = '0;
        vec      = 16'h0000;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                ack_mask    = '0;
                ack_mask[i] = 1'b1;
                vec         = VEC_BASE + 16'(VEC_STRIDE * i);
            end
        end
    end

    // Register-only outputs toward the core, no combinational path from the bus
    assign bus.intreq     = |pend;
    assign bus.intaddress = vec;

    // Next IF/IE: ack clear, then CPU write override, then new edges always OR in
    always_comb begin
        if_d = if_q;
        if (ack_edge) begin
            if_d = if_d & ~ack_mask;
        end
        if (bus.store && if_hit) begin
            if_d = bus.wdata[NSRC-1:0];
        end
        if_d = if_d | rise;

        ie_d = ie_q;
        if (bus.store && ie_hit) begin
            ie_d = bus.wdata;
        end
    end

    // Read mux: unimplemented IF bits read as 1, unmapped addresses read 0xFF
    always_comb begin
        if_rd             = 8'hFF;
        if_rd[NSRC-1:0]   = if_q;
        if (if_hit) begin
            bus.rdata = if_rd;
        end else if (ie_hit) begin
            bus.rdata = ie_q;
        end else begin
            bus.rdata = 8'hFF;
        end
    end

    assign bus.rsel = bus.load & (if_hit | ie_hit);

    // State registers with asynchronous clear
    always_ff @(posedge clock4 or negedge resetn) begin
        if (!resetn) begin
            if_q  <= '0;
            ie_q  <= 8'h00;
            src_q <= '0;
            ack_q <= 1'b0;
        end else begin
            if_q  <= if_d;
            ie_q  <= ie_d;
            src_q <= irq_src;
            ack_q <= bus.intack;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lr_intctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lr_intctl
//  Description : Directed self-checking bench for lr_intctl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lr_intctl;

    logic       clock4;
    logic       resetn;
    logic [4:0] irq_src;

    int n_vec;
    int n_err;

    lr_intctl_if bus ();

    lr_intctl u_dut (
        .clock4  (clock4),
        .resetn  (resetn),
        .irq_src (irq_src),
        .bus     (bus.slave)
    );

    initial clock4 = 1'b0;
    always #5 clock4 = ~clock4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock4);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus.address = a;
        bus.wdata   = d;
        bus.store   = 1'b1;
        step();
        bus.store   = 1'b0;
        bus.address = 16'h0000;
        bus.wdata   = 8'h00;
    endtask

    task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
        bus.address = a;
        bus.load    = 1'b1;
        #1;
        check(tag, {24'h0, bus.rdata}, {24'h0, exp});
        bus.load    = 1'b0;
        bus.address = 16'h0000;
    endtask

    task automatic ack_pulse();
        bus.intack = 1'b1;
        step();
        bus.intack = 1'b0;
        step();
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        resetn      = 1'b0;
        irq_src     = 5'h00;
        bus.address = 16'h0000;
        bus.wdata   = 8'h00;
        bus.load    = 1'b0;
        bus.store   = 1'b0;
        bus.intack  = 1'b0;

        // reset state
        step();
        step();
        check("rst_intreq", {31'h0, bus.intreq}, 32'h0);
        check("rst_intaddr", {16'h0, bus.intaddress}, 32'h0);
        check("rst_rsel", {31'h0, bus.rsel}, 32'h0);
        check("rst_rdata", {24'h0, bus.rdata}, 32'hFF);
        resetn = 1'b1;
        step();

        // level held 10 cycles sets the flag once
        bus_write(16'hFFFF, 8'h01);
        irq_src = 5'b00001;
        step();
        check("lvl_intreq", {31'h0, bus.intreq}, 32'h1);
        check("lvl_intaddr", {16'h0, bus.intaddress}, 32'h0040);
        bus_read("lvl_if", 16'hFF0F, 8'hE1);
        bus_write(16'hFF0F, 8'h00);
        for (int i = 0; i < 8; i++) step();
        bus_read("lvl_once", 16'hFF0F, 8'hE0);
        check("lvl_noreq", {31'h0, bus.intreq}, 32'h0);
        irq_src = 5'b00000;
        step();

        // priority and single-pulse acknowledge
        bus_write(16'hFFFF, 8'h1F);
        bus_write(16'hFF0F, 8'h14);
        check("pri_addr50", {16'h0, bus.intaddress}, 32'h0050);
        ack_pulse();
        bus_read("ack1_if", 16'hFF0F, 8'hF0);
        check("ack1_addr60", {16'h0, bus.intaddress}, 32'h0060);
        ack_pulse();
        check("ack2_intreq", {31'h0, bus.intreq}, 32'h0);
        check("ack2_addr0", {16'h0, bus.intaddress}, 32'h0000);

        // held acknowledge clears exactly one flag
        bus_write(16'hFF0F, 8'h03);
        bus_write(16'hFFFF, 8'h03);
        bus.intack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.intack = 1'b0;
        step();
        bus_read("hold_if", 16'hFF0F, 8'hE2);
        check("hold_addr48", {16'h0, bus.intaddress}, 32'h0048);

        // rise beats a write of zero in the same cycle
        bus_write(16'hFFFF, 8'h1F);
        irq_src     = 5'b00100;
        bus.address = 16'hFF0F;
        bus.wdata   = 8'h00;
        bus.store   = 1'b1;
        step();
        bus.store   = 1'b0;
        bus.address = 16'h0000;
        bus_read("rise_vs_wr", 16'hFF0F, 8'hE4);

        // rise beats an ack of the same bit in the same cycle
        irq_src = 5'b00000;
        step();
        check("rva_addr50", {16'h0, bus.intaddress}, 32'h0050);
        irq_src    = 5'b00100;
        bus.intack = 1'b1;
        step();
        bus.intack = 1'b0;
        irq_src    = 5'b00000;
        step();
        bus_read("rise_vs_ack", 16'hFF0F, 8'hE4);

        // IE register access and decoding
        bus_write(16'hFFFF, 8'hA5);
        bus_read("ie_rdata", 16'hFFFF, 8'hA5);
        bus.address = 16'hFFFF;
        bus.load    = 1'b1;
        #1;
        check("ie_rsel", {31'h0, bus.rsel}, 32'h1);
        bus.address = 16'hC000;
        #1;
        check("miss_rsel", {31'h0, bus.rsel}, 32'h0);
        check("miss_rdata", {24'h0, bus.rdata}, 32'hFF);
        // simultaneous load/store returns the pre-write value
        bus.address = 16'hFFFF;
        bus.wdata   = 8'h5A;
        bus.store   = 1'b1;
        #1;
        check("rw_prewrite", {24'h0, bus.rdata}, 32'hA5);
        step();
        bus.store   = 1'b0;
        bus.load    = 1'b0;
        bus_read("rw_postwrite", 16'hFFFF, 8'h5A);
        bus_write(16'hFFFF, 8'hA5);
        bus_write(16'hFF0F, 8'h1F);
        check("mask_addr40", {16'h0, bus.intaddress}, 32'h0040);

        // cancelled dispatch: ack with nothing enabled leaves IF alone
        bus_write(16'hFFFF, 8'h00);
        ack_pulse();
        bus_read("cancel_if", 16'hFF0F, 8'hFF);
        bus_write(16'hFFFF, 8'h1F);

        // asynchronous reset mid-run, source held through release
        check("pre_rst_req", {31'h0, bus.intreq}, 32'h1);
        resetn  = 1'b0;
        irq_src = 5'b01000;
        #1;
        check("async_rst_req", {31'h0, bus.intreq}, 32'h0);
        bus_read("async_rst_if", 16'hFF0F, 8'hE0);
        step();
        resetn = 1'b1;
        step();
        bus_read("post_rst_if", 16'hFF0F, 8'hE8);
        check("post_rst_noreq", {31'h0, bus.intreq}, 32'h0);
        irq_src = 5'b00000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
